// File: rtl/multiport_out_of_order_buffer_pkg.sv
// Shared helpers for the multiport out-of-order buffer.
// onehot_to_binary encodes a one-hot vector of up to MAX_SLOTS bits into a binary index.
package multiport_out_of_order_buffer_pkg;

    localparam int MAX_SLOTS       = 256;
    localparam int MAX_INDEX_WIDTH = 8;

    function automatic logic [MAX_INDEX_WIDTH-1:0] onehot_to_binary(input logic [MAX_SLOTS-1:0] onehot);
        logic [MAX_INDEX_WIDTH-1:0] index;
        index = '0;
        for (int i = 0; i < MAX_SLOTS; i++) begin
            if (onehot[i]) begin
                index = index | MAX_INDEX_WIDTH'(i);
            end
        end
        return index;
    endfunction

endpackage

// File: rtl/multiport_out_of_order_buffer_first_ones.sv
// first_ones: finds the COUNT lowest set bits of a vector.
// Each result is one-hot, and found[c] flags that at least c+1 bits were set.
module first_ones #(
    parameter int WIDTH = 8,
    parameter int COUNT = 2
) (
    input  logic [WIDTH-1:0]            bits,
    output logic [COUNT-1:0][WIDTH-1:0] onehot,
    output logic [COUNT-1:0]            found
);

    logic [WIDTH-1:0] remaining;

    // x & -x isolates the lowest set bit; peel one off per result
    always_comb begin
        remaining = bits;
        onehot    = '0;
        found     = '0;
        for (int c = 0; c < COUNT; c++) begin
            onehot[c] = remaining & (~remaining + WIDTH'(1));
            found[c]  = |remaining;
            remaining = remaining & ~onehot[c];
        end
    end

endmodule

// File: rtl/multiport_out_of_order_buffer.sv
// Multiport out-of-order buffer: WRITE_PORTS allocate free slots, READ_PORTS read or free any slot.
// Define MULTIPORT_OUT_OF_ORDER_BUFFER_LEVEL_EN to add the registered 'level' occupancy output (DEPTH up to 256).
module multiport_out_of_order_buffer
    import multiport_out_of_order_buffer_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 8,
    parameter int WRITE_PORTS = 2,
    parameter int READ_PORTS  = 2,
    parameter int INDEX_WIDTH = $clog2(DEPTH)
) (
    input  logic                               clock,
    input  logic                               resetn,
    output logic                               full,
    output logic                               empty,
    input  logic [WRITE_PORTS-1:0]             write_enable,
    input  logic [WRITE_PORTS*WIDTH-1:0]       write_data,
    output logic [WRITE_PORTS-1:0]             write_ready,
    output logic [WRITE_PORTS*INDEX_WIDTH-1:0] write_index,
    input  logic [READ_PORTS-1:0]              read_enable,
    input  logic [READ_PORTS-1:0]              read_clear,
    input  logic [READ_PORTS*INDEX_WIDTH-1:0]  read_index,
    output logic [READ_PORTS*WIDTH-1:0]        read_data,
    output logic [READ_PORTS-1:0]              read_error
`ifdef MULTIPORT_OUT_OF_ORDER_BUFFER_LEVEL_EN
    ,
    output logic [INDEX_WIDTH:0]               level
`endif
);

    logic [DEPTH-1:0]                  valid;
    logic [DEPTH-1:0]                  valid_next;
    logic [DEPTH-1:0]                  free_slots;
    logic [DEPTH-1:0]                  write_mask;
    logic [DEPTH-1:0]                  clear_mask;
    logic [WIDTH-1:0]                  buffer [DEPTH];
    logic [WIDTH-1:0]                  write_value [DEPTH];
    logic [WRITE_PORTS-1:0][DEPTH-1:0] free_onehot;
    logic [WRITE_PORTS-1:0]            free_found;
    logic [READ_PORTS-1:0]             read_hit;

    assign free_slots = ~valid;

    first_ones #(
        .WIDTH (DEPTH),
        .COUNT (WRITE_PORTS)
    ) u_first_ones (
        .bits   (free_slots),
        .onehot (free_onehot),
        .found  (free_found)
    );

    // Port p always owns the p-th lowest free slot, so its index never depends on other ports
    always_comb begin
        write_ready = free_found;
        write_index = '0;
        write_mask  = '0;
        for (int s = 0; s < DEPTH; s++) begin
            write_value[s] = '0;
        end
        for (int p = 0; p < WRITE_PORTS; p++) begin
            write_index[p*INDEX_WIDTH +: INDEX_WIDTH] =
                INDEX_WIDTH'(onehot_to_binary(MAX_SLOTS'(free_onehot[p])));
            if (write_enable[p] && free_found[p]) begin
                write_mask = write_mask | free_onehot[p];
                for (int s = 0; s < DEPTH; s++) begin
                    if (free_onehot[p][s]) begin
                        write_value[s] = write_data[p*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    // Decoding by slot compare leaves out-of-range indices with zero data, an error and no clear
    always_comb begin
        read_data  = '0;
        read_error = '0;
        read_hit   = '0;
        clear_mask = '0;
        for (int r = 0; r < READ_PORTS; r++) begin
            for (int s = 0; s < DEPTH; s++) begin
                if (read_index[r*INDEX_WIDTH +: INDEX_WIDTH] == INDEX_WIDTH'(s)) begin
                    read_data[r*WIDTH +: WIDTH] = buffer[s];
                    read_hit[r]                 = valid[s];
                    if (read_enable[r] && read_clear[r]) begin
                        clear_mask[s] = clear_mask[s] | valid[s];
                    end
                end
            end
            read_error[r] = read_enable[r] && !read_hit[r];
        end
    end

    // Writes only hit free slots and clears only valid ones, so the two masks never overlap
    assign valid_next = (valid & ~clear_mask) | write_mask;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
            for (int s = 0; s < DEPTH; s++) begin
                buffer[s] <= '0;
            end
        end else begin
            valid <= valid_next;
            full  <= &valid_next;
            empty <= ~|valid_next;
            for (int s = 0; s < DEPTH; s++) begin
                if (write_mask[s]) begin
                    buffer[s] <= write_value[s];
                end
            end
        end
    end

`ifdef MULTIPORT_OUT_OF_ORDER_BUFFER_LEVEL_EN
    localparam int LEVEL_WIDTH = INDEX_WIDTH + 1;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            level <= '0;
        end else begin
            level <= level + LEVEL_WIDTH'($countones(write_mask)) - LEVEL_WIDTH'($countones(clear_mask));
        end
    end
`endif

endmodule

// File: tb/tb_multiport_out_of_order_buffer.sv
// Self-checking bench for multiport_out_of_order_buffer: directed vector table, corner sequences and
// randomized traffic compared against a slot-list reference model. Honours MULTIPORT_OUT_OF_ORDER_BUFFER_LEVEL_EN.
module tb_multiport_out_of_order_buffer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int WP    = 2;
    localparam int RP    = 2;
    localparam int IW    = 3;

    logic              clock = 1'b0;
    logic              resetn;
    logic              full;
    logic              empty;
    logic [WP-1:0]     write_enable = '0;
    logic [WP*WIDTH-1:0] write_data = '0;
    logic [WP-1:0]     write_ready;
    logic [WP*IW-1:0]  write_index;
    logic [RP-1:0]     read_enable = '0;
    logic [RP-1:0]     read_clear = '0;
    logic [RP*IW-1:0]  read_index = '0;
    logic [RP*WIDTH-1:0] read_data;
    logic [RP-1:0]     read_error;
`ifdef MULTIPORT_OUT_OF_ORDER_BUFFER_LEVEL_EN
    logic [IW:0]       level;
    logic [IW:0]       s_level;
    logic [IW:0]       level_before;
`endif

    int tests = 0;
    int fails = 0;

    logic             mv [DEPTH];
    logic [WIDTH-1:0] md [DEPTH];

    logic [WP-1:0]       s_ready;
    logic [WP*IW-1:0]    s_index;
    logic [RP*WIDTH-1:0] s_rdata;
    logic [RP-1:0]       s_rerr;
    logic                s_full;
    logic                s_empty;

    typedef struct {
        logic [1:0]  we;
        logic [15:0] wd;
        logic [1:0]  re;
        logic [1:0]  rc;
        logic [5:0]  ri;
        logic [1:0]  ready;
        logic [5:0]  index;
        logic [15:0] rdata;
        logic [1:0]  rerr;
        logic        empty;
        logic        full;
    } vec_t;

    vec_t vectors [7];

    always #5 clock = ~clock;

    multiport_out_of_order_buffer #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .WRITE_PORTS (WP),
        .READ_PORTS  (RP),
        .INDEX_WIDTH (IW)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .full         (full),
        .empty        (empty),
        .write_enable (write_enable),
        .write_data   (write_data),
        .write_ready  (write_ready),
        .write_index  (write_index),
        .read_enable  (read_enable),
        .read_clear   (read_clear),
        .read_index   (read_index),
        .read_data    (read_data),
        .read_error   (read_error)
`ifdef MULTIPORT_OUT_OF_ORDER_BUFFER_LEVEL_EN
        ,
        .level        (level)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sampleOutputs();
        s_ready = write_ready;
        s_index = write_index;
        s_rdata = read_data;
        s_rerr  = read_error;
        s_full  = full;
        s_empty = empty;
`ifdef MULTIPORT_OUT_OF_ORDER_BUFFER_LEVEL_EN
        s_level = level;
`endif
    endtask

    // Compare sampled outputs with what the slot-list model predicts for the current inputs
    task automatic checkOutput();
        int free_list[$];
        int count;
        int idx;
        logic             in_range;
        logic [WIDTH-1:0] exp_data;
        logic             exp_err;
        count = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!mv[i]) free_list.push_back(i);
            else count++;
        end
        for (int p = 0; p < WP; p++) begin
            check($sformatf("write_ready[%0d]", p), 32'(s_ready[p]), 32'(free_list.size() > p));
            if (free_list.size() > p) begin
                check($sformatf("write_index[%0d]", p), 32'(s_index[p*IW +: IW]), 32'(free_list[p]));
            end
        end
        for (int r = 0; r < RP; r++) begin
            idx      = int'(read_index[r*IW +: IW]);
            in_range = idx < DEPTH;
            exp_data = in_range ? md[idx] : '0;
            exp_err  = read_enable[r] && !(in_range && mv[idx]);
            check($sformatf("read_data[%0d]", r), 32'(s_rdata[r*WIDTH +: WIDTH]), 32'(exp_data));
            check($sformatf("read_error[%0d]", r), 32'(s_rerr[r]), 32'(exp_err));
        end
        check("full", 32'(s_full), 32'(count == DEPTH));
        check("empty", 32'(s_empty), 32'(count == 0));
`ifdef MULTIPORT_OUT_OF_ORDER_BUFFER_LEVEL_EN
        check("level", 32'(s_level), 32'(count));
`endif
    endtask

    // One clock: drive inputs, check at the falling edge, then advance the model past the rising edge
    task automatic applyStimulus(input logic [1:0] we, input logic [15:0] wd, input logic [1:0] re,
                                 input logic [1:0] rc, input logic [5:0] ri);
        logic             nv [DEPTH];
        logic [WIDTH-1:0] nd [DEPTH];
        int free_list[$];
        int idx;
        write_enable = we;
        write_data   = wd;
        read_enable  = re;
        read_clear   = rc;
        read_index   = ri;
        @(negedge clock);
        sampleOutputs();
        checkOutput();
        nv = mv;
        nd = md;
        for (int i = 0; i < DEPTH; i++) begin
            if (!mv[i]) free_list.push_back(i);
        end
        for (int r = 0; r < RP; r++) begin
            idx = int'(ri[r*IW +: IW]);
            if (re[r] && rc[r] && idx < DEPTH && mv[idx]) nv[idx] = 1'b0;
        end
        for (int p = 0; p < WP; p++) begin
            if (we[p] && free_list.size() > p) begin
                nv[free_list[p]] = 1'b1;
                nd[free_list[p]] = wd[p*WIDTH +: WIDTH];
            end
        end
        @(posedge clock);
        #1;
        mv = nv;
        md = nd;
    endtask

    task automatic doReset(input logic [1:0] re, input logic [5:0] ri);
        write_enable = '0;
        read_clear   = '0;
        read_enable  = re;
        read_index   = ri;
        resetn       = 1'b0;
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            mv[i] = 1'b0;
            md[i] = '0;
        end
        sampleOutputs();
        check("reset_full", 32'(s_full), 32'h0);
        check("reset_empty", 32'(s_empty), 32'h1);
        check("reset_write_ready", 32'(s_ready), 32'h3);
        check("reset_read_error", 32'(s_rerr), 32'(re));
`ifdef MULTIPORT_OUT_OF_ORDER_BUFFER_LEVEL_EN
        check("reset_level", 32'(s_level), 32'h0);
`endif
        @(posedge clock);
        @(negedge clock);
        read_enable = '0;
        resetn      = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        // we, wd, re, rc, ri | ready, index, rdata, rerr, empty, full
        vectors[0] = '{2'b00, 16'h0000, 2'b01, 2'b01, {3'd0, 3'd5}, 2'b11, {3'd1, 3'd0}, 16'h0000, 2'b01, 1'b1, 1'b0};
        vectors[1] = '{2'b11, 16'hB2A1, 2'b00, 2'b00, {3'd0, 3'd0}, 2'b11, {3'd1, 3'd0}, 16'h0000, 2'b00, 1'b1, 1'b0};
        vectors[2] = '{2'b00, 16'h0000, 2'b01, 2'b00, {3'd0, 3'd1}, 2'b11, {3'd3, 3'd2}, 16'hA1B2, 2'b00, 1'b0, 1'b0};
        vectors[3] = '{2'b01, 16'h00C3, 2'b11, 2'b10, {3'd0, 3'd1}, 2'b11, {3'd3, 3'd2}, 16'hA1B2, 2'b00, 1'b0, 1'b0};
        vectors[4] = '{2'b11, 16'hE5D4, 2'b11, 2'b00, {3'd0, 3'd2}, 2'b11, {3'd3, 3'd0}, 16'hA1C3, 2'b10, 1'b0, 1'b0};
        vectors[5] = '{2'b10, 16'hF600, 2'b00, 2'b00, {3'd3, 3'd0}, 2'b11, {3'd5, 3'd4}, 16'hE5D4, 2'b00, 1'b0, 1'b0};
        vectors[6] = '{2'b00, 16'h0000, 2'b11, 2'b00, {3'd5, 3'd4}, 2'b11, {3'd6, 3'd4}, 16'hF600, 2'b01, 1'b0, 1'b0};

        resetn = 1'b1;
        #2;
        doReset(2'b00, 6'd0);

        // Directed table: invalid-slot read after reset, dual write, no bypass, out-of-order reuse
        for (int i = 0; i < $size(vectors); i++) begin
            applyStimulus(vectors[i].we, vectors[i].wd, vectors[i].re, vectors[i].rc, vectors[i].ri);
            check($sformatf("vec%0d_ready", i), 32'(s_ready), 32'(vectors[i].ready));
            check($sformatf("vec%0d_index", i), 32'(s_index), 32'(vectors[i].index));
            check($sformatf("vec%0d_rdata", i), 32'(s_rdata), 32'(vectors[i].rdata));
            check($sformatf("vec%0d_rerr", i), 32'(s_rerr), 32'(vectors[i].rerr));
            check($sformatf("vec%0d_empty", i), 32'(s_empty), 32'(vectors[i].empty));
            check($sformatf("vec%0d_full", i), 32'(s_full), 32'(vectors[i].full));
        end

        // Fill seven slots, then only port 0 can take the last one
        doReset(2'b00, 6'd0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2'b11, {8'(8'h21 + 2*k), 8'(8'h20 + 2*k)}, 2'b00, 2'b00, 6'd0);
        end
        applyStimulus(2'b01, 16'h0026, 2'b00, 2'b00, 6'd0);
        applyStimulus(2'b11, 16'h9977, 2'b00, 2'b00, 6'd0);
        check("last_slot_ready", 32'(s_ready), 32'h1);
        check("last_slot_index", 32'(s_index[2:0]), 32'h7);
        applyStimulus(2'b00, 16'h0000, 2'b01, 2'b00, {3'd0, 3'd7});
        check("full_after_fill", 32'(s_full), 32'h1);
        check("full_ready", 32'(s_ready), 32'h0);
        check("slot7_data", 32'(s_rdata[7:0]), 32'h77);

        // Clear and write together while full: write is refused, freed slot offered next cycle
        applyStimulus(2'b01, 16'h0055, 2'b01, 2'b01, {3'd0, 3'd2});
        check("full_clear_ready", 32'(s_ready), 32'h0);
        check("full_clear_data", 32'(s_rdata[7:0]), 32'h22);
        applyStimulus(2'b00, 16'h0000, 2'b00, 2'b00, 6'd0);
        check("reuse_index", 32'(s_index[2:0]), 32'h2);
        check("reuse_full", 32'(s_full), 32'h0);
        check("reuse_ready", 32'(s_ready), 32'h1);

        // Both read ports clear slot 3 in the same cycle
`ifdef MULTIPORT_OUT_OF_ORDER_BUFFER_LEVEL_EN
        level_before = s_level;
`endif
        applyStimulus(2'b00, 16'h0000, 2'b11, 2'b11, {3'd3, 3'd3});
        check("dual_clear_data", 32'(s_rdata), 32'h2323);
        check("dual_clear_err", 32'(s_rerr), 32'h0);
        applyStimulus(2'b00, 16'h0000, 2'b01, 2'b00, {3'd0, 3'd3});
        check("dual_clear_gone", 32'(s_rerr), 32'h1);
`ifdef MULTIPORT_OUT_OF_ORDER_BUFFER_LEVEL_EN
        check("dual_clear_level", 32'(s_level), 32'(level_before - 1'b1));
`endif

        // Trim to four valid slots, then reset mid-stream with both ports reading valid slots
        applyStimulus(2'b00, 16'h0000, 2'b11, 2'b11, {3'd5, 3'd4});
        applyStimulus(2'b00, 16'h0000, 2'b00, 2'b00, 6'd0);
        check("four_valid_empty", 32'(s_empty), 32'h0);
        doReset(2'b11, {3'd1, 3'd0});

        // Randomized traffic alternating fill-biased and drain-biased phases
        for (int i = 0; i < 400; i++) begin
            logic [1:0] we;
            logic [1:0] rc;
            if (((i / 40) % 2) == 0) begin
                we = 2'($urandom_range(0, 3));
                rc = 2'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 0);
            end else begin
                we = {1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0)};
                rc = 2'($urandom_range(0, 3));
            end
            applyStimulus(we, 16'($urandom), 2'($urandom_range(0, 3)), rc, 6'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
